// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: registered request, byte-lane alignment,
// load extension and fault reporting over a valid/ready memory port.
module lsu_mc #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MREQ,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        size_q;
  logic [XLEN-1:0]   rdata_q;
  logic [1:0]        err_q;
  logic [CW-1:0]     cnt;

  logic [OFFW-1:0]   off;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   ext;
  logic [NB-1:0]     bmask;
  logic [2:0]        amask;
  logic              sgn;
  logic              illegal;
  logic              tmo;
  int                nbits;

  assign off = addr_q[OFFW-1:0];
  assign sh  = mem_rsp_rdata >> {off, 3'b000};

  // A request is illegal if misaligned, wider than the bus, or a store
  // with the zero-extend bit set.
  assign amask   = 3'((4'd1 << req_size[1:0]) - 4'd1);
  assign illegal = (|(req_addr[2:0] & amask))
                 || (int'(req_size[1:0]) > OFFW)
                 || (req_wen && req_size[2]);

  assign tmo = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);

  always_comb begin
    nbits = 8 << size_q[1:0];
    unique case (size_q[1:0])
      2'd1:    sgn = sh[15];
      2'd2:    sgn = sh[31];
      2'd3:    sgn = sh[XLEN-1];
      default: sgn = sh[7];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      ext[i] = (i < nbits) ? sh[i] : (sgn & ~size_q[2]);
    end
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bmask[i] = (i >= int'(off))
              && (i < int'(off) + (1 << size_q[1:0]));
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_valid)     state_n = illegal ? RESP : MREQ;
      MREQ: if (mem_req_ready) state_n = WAIT;
      WAIT: if (mem_rsp_valid || tmo) state_n = RESP;
      RESP: if (rsp_ready)     state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (req_valid) begin
          wen_q   <= req_wen;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          rdata_q <= '0;
          err_q   <= illegal ? 2'b01 : 2'b00;
        end
        MREQ: if (mem_req_ready) cnt <= '0;
        WAIT: begin
          // A response in the limit cycle takes priority over timeout.
          if (mem_rsp_valid) begin
            err_q   <= mem_rsp_err ? 2'b10 : 2'b00;
            rdata_q <= (mem_rsp_err || wen_q) ? '0 : ext;
          end else if (tmo) begin
            err_q   <= 2'b11;
            rdata_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (state == IDLE) && rst_n;
  assign rsp_valid     = (state == RESP);
  assign rsp_rdata     = rsp_valid ? rdata_q : '0;
  assign rsp_err       = rsp_valid ? err_q : 2'b00;
  assign mem_req_valid = (state == MREQ);
  assign mem_req_wen   = mem_req_valid && wen_q;
  assign mem_req_addr  = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign mem_req_wdata = wdata_q << {off, 3'b000};
  assign mem_req_wmask = mem_req_valid ? bmask : '0;

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: 32- and 64-bit instances driven from a vector table,
// with a response scoreboard and hand-written reset/timeout sequences.
module tb_lsu_mc;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel64;
  logic        req_valid, req_wen, rsp_ready;
  logic        mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rsp_rdata;
  logic [2:0]  req_size;

  logic        rr32, rv32, mv32, mw32;
  logic [31:0] rd32, ma32, mwd32;
  logic [1:0]  re32;
  logic [3:0]  mm32;
  logic        rr64, rv64, mv64, mw64;
  logic [63:0] rd64, mwd64;
  logic [31:0] ma64;
  logic [1:0]  re64;
  logic [7:0]  mm64;

  lsu_mc #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel64), .req_ready(rr32),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .req_size(req_size),
    .rsp_valid(rv32), .rsp_ready(rsp_ready),
    .rsp_rdata(rd32), .rsp_err(re32),
    .mem_req_valid(mv32), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mw32), .mem_req_addr(ma32),
    .mem_req_wdata(mwd32), .mem_req_wmask(mm32),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata[31:0]),
    .mem_rsp_err(mem_rsp_err)
  );

  lsu_mc #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel64), .req_ready(rr64),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rv64), .rsp_ready(rsp_ready),
    .rsp_rdata(rd64), .rsp_err(re64),
    .mem_req_valid(mv64), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mw64), .mem_req_addr(ma64),
    .mem_req_wdata(mwd64), .mem_req_wmask(mm64),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  logic        o_rr, o_rv, o_mv, o_mw;
  logic [63:0] o_rd, o_mwd;
  logic [31:0] o_ma;
  logic [1:0]  o_re;
  logic [7:0]  o_mm;

  assign o_rr  = sel64 ? rr64 : rr32;
  assign o_rv  = sel64 ? rv64 : rv32;
  assign o_mv  = sel64 ? mv64 : mv32;
  assign o_mw  = sel64 ? mw64 : mw32;
  assign o_rd  = sel64 ? rd64 : {32'b0, rd32};
  assign o_mwd = sel64 ? mwd64 : {32'b0, mwd32};
  assign o_ma  = sel64 ? ma64 : ma32;
  assign o_re  = sel64 ? re64 : re32;
  assign o_mm  = sel64 ? mm64 : {4'b0, mm32};

  typedef struct {
    bit          w64;
    bit          wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic [63:0] mrdata;
    bit          merr;
    int          rqd;
    int          rsd;
    int          hold;
    logic [1:0]  err;
    logic [63:0] rdata;
    logic [7:0]  wmask;
    logic [63:0] mwdata;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    int          lat;
    bit          got, ok, mem;
    logic [31:0] ea;
    sel64 = v.w64;
    ea  = v.w64 ? (v.addr & ~32'h7) : (v.addr & ~32'h3);
    mem = (v.err != 2'b01);
    e.rdata = v.rdata;
    e.err   = v.err;
    e.lat   = !mem ? 1 : 2 + v.rqd + (v.rsd < 0 ? TO : v.rsd + 1);
    sb.push_back(e);
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_size  = v.size;
    req_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready", 64'(o_rr), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    if (mem) begin
      ok = 1'b1;
      for (int i = 0; i < v.rqd; i++) begin
        @(negedge clk);
        ok &= o_mv && o_ma == ea && o_mm == v.wmask
           && o_mwd == v.mwdata && o_mw == v.wen && !o_rv;
        @(posedge clk); #1;
        lat++;
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("mreq_valid", 64'(o_mv), 64'd1);
      chk("mreq_addr", 64'(o_ma), 64'(ea));
      chk("mreq_wmask", 64'(o_mm), 64'(v.wmask));
      chk("mreq_wdata", o_mwd, v.mwdata);
      chk("mreq_wen", 64'(o_mw), 64'(v.wen));
      if (v.rqd > 0) chk("mreq_stall_stable", 64'(ok), 64'd1);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      lat++;
      if (v.rsd >= 0) begin
        repeat (v.rsd) begin
          @(posedge clk); #1;
          lat++;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = v.mrdata;
        mem_rsp_err   = v.merr;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        lat++;
      end
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (o_rv) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("rsp_arrived", 64'(got), 64'd1);
    if (sb.size() > 0) e = sb.pop_front();
    if (!got) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end
    chk("rsp_latency", 64'(lat), 64'(e.lat));
    chk("rsp_rdata", o_rd, e.rdata);
    chk("rsp_err", 64'(o_re), 64'(e.err));
    chk("busy_not_ready", 64'(o_rr), 64'd0);
    chk("wmask_idle", 64'(o_mm), 64'd0);
    if (!mem) chk("no_mreq", 64'(o_mv), 64'd0);
    ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      // late memory responses must not disturb a held result
      if (v.rsd < 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = v.mrdata;
      end
      @(posedge clk); #1;
      @(negedge clk);
      ok &= o_rv && o_rd == e.rdata && o_re == e.err;
    end
    mem_rsp_valid = 1'b0;
    if (v.hold > 0) chk("rsp_hold", 64'(ok), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_done", 64'(o_rv), 64'd0);
    chk("ready_again", 64'(o_rr), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    vt.push_back('{1'b0, 1'b0, 32'h80000003, 64'h0, 3'b000, 64'h80FF1234,
                   1'b0, 0, 0, 0, 2'b00, 64'hFFFFFF80, 8'h08, 64'h0});
    vt.push_back('{1'b0, 1'b1, 32'h80000002, 64'hABCD, 3'b001, 64'hDEADBEEF,
                   1'b0, 0, 0, 0, 2'b00, 64'h0, 8'h0C, 64'hABCD0000});
    vt.push_back('{1'b0, 1'b0, 32'h80000006, 64'h0, 3'b010, 64'h0,
                   1'b0, 0, 0, 0, 2'b01, 64'h0, 8'h00, 64'h0});
    vt.push_back('{1'b0, 1'b0, 32'h80000000, 64'h0, 3'b011, 64'h0,
                   1'b0, 0, 0, 0, 2'b01, 64'h0, 8'h00, 64'h0});
    vt.push_back('{1'b0, 1'b0, 32'h80000001, 64'h0, 3'b100, 64'h80FF1234,
                   1'b0, 0, 0, 0, 2'b00, 64'h12, 8'h02, 64'h0});
    vt.push_back('{1'b0, 1'b0, 32'h80000002, 64'h0, 3'b001, 64'h80FF1234,
                   1'b0, 0, 0, 1, 2'b00, 64'hFFFF80FF, 8'h0C, 64'h0});
    vt.push_back('{1'b0, 1'b0, 32'h80000002, 64'h0, 3'b101, 64'h80FF1234,
                   1'b0, 0, 0, 0, 2'b00, 64'h80FF, 8'h0C, 64'h0});
    vt.push_back('{1'b0, 1'b0, 32'h80000000, 64'h0, 3'b010, 64'h55AA55AA,
                   1'b1, 0, 0, 0, 2'b10, 64'h0, 8'h0F, 64'h0});
    vt.push_back('{1'b0, 1'b1, 32'h80000001, 64'h77, 3'b100, 64'h0,
                   1'b0, 0, 0, 0, 2'b01, 64'h0, 8'h00, 64'h0});
    vt.push_back('{1'b0, 1'b1, 32'h80000004, 64'h11223344, 3'b010, 64'h0,
                   1'b0, 10, 0, 0, 2'b00, 64'h0, 8'h0F, 64'h11223344});
    vt.push_back('{1'b0, 1'b0, 32'h80000008, 64'h0, 3'b010, 64'hCAFE,
                   1'b0, 0, -1, 3, 2'b11, 64'h0, 8'h0F, 64'h0});
    vt.push_back('{1'b0, 1'b0, 32'h8000000C, 64'h0, 3'b010, 64'h92345678,
                   1'b0, 0, 3, 0, 2'b00, 64'h92345678, 8'h0F, 64'h0});
    vt.push_back('{1'b1, 1'b0, 32'h80000004, 64'h0, 3'b110,
                   64'h8765432100000000, 1'b0, 0, 0, 0, 2'b00,
                   64'h0000000087654321, 8'hF0, 64'h0});
    vt.push_back('{1'b1, 1'b0, 32'h80000004, 64'h0, 3'b010,
                   64'h8765432100000000, 1'b0, 0, 0, 0, 2'b00,
                   64'hFFFFFFFF87654321, 8'hF0, 64'h0});
    vt.push_back('{1'b1, 1'b0, 32'h80000008, 64'h0, 3'b011,
                   64'h0123456789ABCDEF, 1'b0, 0, 1, 0, 2'b00,
                   64'h0123456789ABCDEF, 8'hFF, 64'h0});
    vt.push_back('{1'b1, 1'b1, 32'h80000006, 64'hBEEF, 3'b001, 64'h0,
                   1'b0, 0, 0, 0, 2'b00, 64'h0, 8'hC0,
                   64'hBEEF000000000000});
    vt.push_back('{1'b1, 1'b0, 32'h80000002, 64'h0, 3'b010, 64'h0,
                   1'b0, 0, 0, 0, 2'b01, 64'h0, 8'h00, 64'h0});
    vt.push_back('{1'b1, 1'b0, 32'h80000007, 64'h0, 3'b000,
                   64'h7F00000000000000, 1'b0, 0, 0, 0, 2'b00,
                   64'h7F, 8'h80, 64'h0});

    rst_n = 1'b0;
    sel64 = 1'b0;
    req_valid = 1'b0;
    req_wen = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_size = '0;
    rsp_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready32", 64'(rr32), 64'd0);
    chk("rst_ready64", 64'(rr64), 64'd0);
    chk("rst_rsp_valid", 64'(rv32 | rv64), 64'd0);
    chk("rst_mreq_valid", 64'(mv32 | mv64), 64'd0);
    chk("rst_wmask", 64'({mm32, mm64}), 64'd0);
    chk("rst_rdata", rd64 | {32'b0, rd32}, 64'd0);
    chk("rst_maddr", 64'(ma32 | ma64), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready32", 64'(rr32), 64'd1);
    chk("release_ready64", 64'(rr64), 64'd1);
    @(posedge clk); #1;

    for (int k = 0; k < vt.size(); k++) run_vec(vt[k]);

    // abort an access in WAIT with reset, then complete a fresh load
    sel64 = 1'b0;
    req_wen = 1'b0;
    req_addr = 32'h80000010;
    req_size = 3'b010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("wait_busy", 64'(o_rr), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(o_rv), 64'd0);
    chk("midrst_mreq_valid", 64'(o_mv), 64'd0);
    chk("midrst_ready", 64'(o_rr), 64'd0);
    chk("midrst_wmask", 64'(o_mm), 64'd0);
    chk("midrst_maddr", 64'(o_ma), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h5A5A5A5A;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 64'(o_rr), 64'd1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("postrst_no_rsp", 64'(o_rv), 64'd0);
    chk("postrst_no_mreq", 64'(o_mv), 64'd0);
    @(posedge clk); #1;
    run_vec('{1'b0, 1'b0, 32'h80000010, 64'h0, 3'b010, 64'h0BADF00D,
              1'b0, 0, 0, 0, 2'b00, 64'h0BADF00D, 8'h0F, 64'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
